// File: rtl/imem_boot_loader_if.sv
// Bus bundle between the boot loader and its neighbours. The first group of
// signals is the streaming word source (valid/ready). The second group is the
// fetch-stage instruction-memory load port.
// The loader uses the slave modport. The source/fetch side uses the master modport.
interface imem_boot_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              load_mem_en;
    logic [ADDR_W-1:0] load_mem_addr;
    logic [DATA_W-1:0] load_mem_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  load_mem_en,
        input  load_mem_addr,
        input  load_mem_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output load_mem_en,
        output load_mem_addr,
        output load_mem_data
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader for the 32-word fetch-stage instruction memory.
// It streams word_count words into the memory from address 0 upward. It then
// pulses the core reset for one cycle so the PC restarts at 0, and lets the core run.
// While the core runs, pipeline hazard stalls pass straight through to fetch.
module imem_boot_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    imem_boot_loader_if.slave bus,
    output logic              core_rst_n,
    input  logic              stall_req,
    output logic              fetch_stall,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(1);

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W:0]   remaining_r;
    logic [ADDR_W:0]   remaining_s;
    logic              core_rst_n_r;
    logic              error_r;
    logic              error_s;
    logic              wc_legal_s;
    logic              in_ready_s;
    logic              load_fire_s;

    // A load length of 1..DEPTH words is legal.
    assign wc_legal_s = (word_count != '0) && (word_count <= DEPTH_C);

    // Abort wins over a handshake, so ready drops in the abort cycle and nothing is written.
    assign in_ready_s  = (state_r == ST_LOAD) && !abort;
    assign load_fire_s = bus.in_valid && in_ready_s;

    assign bus.in_ready      = in_ready_s;
    assign bus.load_mem_en   = load_fire_s;
    assign bus.load_mem_addr = addr_r;
    assign bus.load_mem_data = load_fire_s ? bus.in_data : '0;

    assign fetch_stall = (state_r == ST_RUN) ? stall_req : 1'b1;
    assign busy        = (state_r == ST_LOAD) || (state_r == ST_RELEASE);
    assign done        = (state_r == ST_RUN);
    assign core_rst_n  = core_rst_n_r;
    assign error       = error_r;

    // Next-state and counter logic. Abort overrides everything else.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        remaining_s = remaining_r;
        error_s     = 1'b0;
        if (abort) begin
            state_s     = ST_IDLE;
            addr_s      = '0;
            remaining_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && wc_legal_s) begin
                        state_s     = ST_LOAD;
                        addr_s      = '0;
                        remaining_s = word_count;
                    end else if (start) begin
                        error_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (load_fire_s) begin
                        addr_s      = addr_r + STEP_C;
                        remaining_s = remaining_r - ONE_C;
                        if (remaining_r == ONE_C) begin
                            state_s = ST_RELEASE;
                        end else begin
                            state_s = ST_LOAD;
                        end
                    end else begin
                        state_s = ST_LOAD;
                    end
                end
                ST_RELEASE: begin
                    state_s = ST_RUN;
                end
                ST_RUN: begin
                    state_s = ST_RUN;
                end
                default: begin
                    state_s     = ST_IDLE;
                    addr_s      = '0;
                    remaining_s = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs. The core is held in reset
    // except while loading or running, so RELEASE gives a one-cycle reset pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            addr_r       <= '0;
            remaining_r  <= '0;
            core_rst_n_r <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            addr_r       <= addr_s;
            remaining_r  <= remaining_s;
            core_rst_n_r <= (state_s == ST_LOAD) || (state_s == ST_RUN);
            error_r      <= error_s;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader.
// Stimulus pushes every write it expects (address, data) into a queue. An
// independent monitor pops and compares on each load_mem_en it observes.
// Status outputs are checked against the phase the load sequence is in.
module tb_imem_boot_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] word_count = 6'd0;
    logic       abort = 1'b0;
    logic       stall_req = 1'b0;
    logic       core_rst_n;
    logic       fetch_stall;
    logic       busy;
    logic       done;
    logic       error;

    int total = 0;
    int bad   = 0;

    logic [36:0] exp_q[$];
    logic [36:0] exp_e;

    imem_boot_loader_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    imem_boot_loader #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .word_count  (word_count),
        .abort       (abort),
        .bus         (bus),
        .core_rst_n  (core_rst_n),
        .stall_req   (stall_req),
        .fetch_stall (fetch_stall),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each observed memory write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.load_mem_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", bus.load_mem_en, 1'b0);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wr_addr", bus.load_mem_addr, exp_e[36:32]);
                chk("wr_data", bus.load_mem_data, exp_e[31:0]);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_load(int n);
        start = 1'b1;
        word_count = 6'(n);
        next();
        start = 1'b0;
        word_count = 6'($urandom);
    endtask

    // Offer words until n have been accepted. mode 0 = always valid,
    // 1 = valid every other cycle, 2 = random. fixed >= 0 gives data fixed+i.
    task automatic feed(int n, int mode, int base, int fixed);
        int i = 0;
        int budget = 0;
        while (i < n && budget < 400) begin
            logic v;
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (budget % 2) == 0;
            else                v = 1'($urandom_range(0, 1));
            bus.in_valid = v;
            bus.in_data  = (fixed >= 0) ? 32'(fixed + i) : $urandom;
            stall_req    = 1'($urandom_range(0, 1));
            if (v) exp_q.push_back({5'(base + i), bus.in_data});
            @(negedge clk);
            chk("load_in_ready", bus.in_ready, 1'b1);
            chk("load_core_rst_n", core_rst_n, 1'b1);
            chk("load_fetch_stall", fetch_stall, 1'b1);
            chk("load_busy", busy, 1'b1);
            chk("load_done", done, 1'b0);
            chk("load_error", error, 1'b0);
            next();
            if (v) i++;
            budget++;
        end
        bus.in_valid = 1'b0;
        if (i < n) chk("load_budget", 64'(i), 64'(n));
    endtask

    // After the last word: an extra word is offered but must be refused.
    // Then comes the one-cycle core reset pulse, then RUN.
    task automatic finish_load();
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        @(negedge clk);
        chk("extra_word_ready", bus.in_ready, 1'b0);
        chk("release_core_rst_n", core_rst_n, 1'b0);
        chk("release_busy", busy, 1'b1);
        chk("release_done", done, 1'b0);
        next();
        @(negedge clk);
        chk("run_done", done, 1'b1);
        chk("run_core_rst_n", core_rst_n, 1'b1);
        chk("run_busy", busy, 1'b0);
        chk("run_in_ready", bus.in_ready, 1'b0);
        chk("all_words_written", 64'(exp_q.size()), 64'd0);
        next();
        bus.in_valid = 1'b0;
    endtask

    task automatic leave_run();
        abort = 1'b1;
        next();
        abort = 1'b0;
        stall_req = 1'b0;
        @(negedge clk);
        chk("abort_core_rst_n", core_rst_n, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_fetch_stall", fetch_stall, 1'b1);
        next();
    endtask

    task automatic bad_start(int n);
        start = 1'b1;
        word_count = 6'(n);
        bus.in_valid = 1'b1;
        next();
        start = 1'b0;
        @(negedge clk);
        chk("err_pulse", error, 1'b1);
        chk("err_busy", busy, 1'b0);
        chk("err_in_ready", bus.in_ready, 1'b0);
        next();
        @(negedge clk);
        chk("err_pulse_end", error, 1'b0);
        chk("err_stay_idle", busy, 1'b0);
        bus.in_valid = 1'b0;
        next();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hDEAD_BEEF;
        #3;
        chk("rst_core_rst_n", core_rst_n, 1'b0);
        chk("rst_fetch_stall", fetch_stall, 1'b1);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_mem_en", bus.load_mem_en, 1'b0);
        chk("rst_mem_addr", bus.load_mem_addr, 5'd0);
        chk("rst_mem_data", bus.load_mem_data, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        next();
        next();
        rst_n = 1'b1;

        // Idle with no start: core stays held, fetch stays stalled.
        for (int k = 0; k < 5; k++) begin
            stall_req = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk("idle_core_rst_n", core_rst_n, 1'b0);
            chk("idle_fetch_stall", fetch_stall, 1'b1);
            chk("idle_in_ready", bus.in_ready, 1'b0);
            chk("idle_done", done, 1'b0);
            next();
        end
        bus.in_valid = 1'b0;

        // Four words 0xA0..0xA3 back to back.
        begin_load(4);
        feed(4, 0, 0, 32'hA0);
        finish_load();

        // Stall pass-through in RUN: exactly the three requested cycles.
        for (int k = 0; k < 5; k++) begin
            stall_req = (k < 3);
            @(negedge clk);
            chk("run_stall_pass", fetch_stall, 64'(k < 3));
            next();
        end
        // A start in RUN is ignored.
        start = 1'b1;
        word_count = 6'd4;
        bus.in_valid = 1'b1;
        next();
        start = 1'b0;
        @(negedge clk);
        chk("run_start_ignored_done", done, 1'b1);
        chk("run_start_ignored_busy", busy, 1'b0);
        chk("run_start_ignored_ready", bus.in_ready, 1'b0);
        next();
        bus.in_valid = 1'b0;
        leave_run();

        // Full depth with valid toggling every other cycle.
        begin_load(32);
        feed(32, 1, 0, -1);
        finish_load();
        leave_run();

        // Illegal lengths.
        bad_start(0);
        bad_start(33);
        bad_start(63);

        // Abort together with a start in IDLE: nothing happens.
        start = 1'b1;
        abort = 1'b1;
        word_count = 6'd5;
        next();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_start_busy", busy, 1'b0);
        chk("abort_start_error", error, 1'b0);
        next();

        // Abort after two words, coincident with a third handshake.
        begin_load(5);
        feed(2, 0, 0, -1);
        abort = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = $urandom;
        @(negedge clk);
        chk("abort_no_write", bus.load_mem_en, 1'b0);
        next();
        abort = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", busy, 1'b0);
        chk("abort_idle_core_rst_n", core_rst_n, 1'b0);
        next();
        begin_load(1);
        feed(1, 0, 0, -1);
        finish_load();
        leave_run();

        // Reset in the middle of a load: a partial load is not resumed.
        begin_load(6);
        feed(3, 0, 0, -1);
        bus.in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 1'b0);
        chk("midrst_mem_en", bus.load_mem_en, 1'b0);
        chk("midrst_core_rst_n", core_rst_n, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_addr", bus.load_mem_addr, 5'd0);
        next();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_stays_idle", busy, 1'b0);
        next();
        bus.in_valid = 1'b0;
        begin_load(3);
        feed(3, 2, 0, -1);
        finish_load();
        leave_run();

        // Random lengths and valid patterns, with random stall traffic in RUN.
        for (int r = 0; r < 6; r++) begin
            int n;
            int m;
            n = $urandom_range(1, 32);
            m = $urandom_range(0, 2);
            begin_load(n);
            feed(n, m, 0, -1);
            finish_load();
            for (int k = 0; k < 4; k++) begin
                stall_req = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("rand_run_stall", fetch_stall, stall_req);
                next();
            end
            leave_run();
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
